// File: rtl/pwm_peripheral.sv
// Prescaled 8-bit PWM shared across 16 outputs, each gated by its enable bits.
// Define PWM_DUTY_SHADOW_EN to double-buffer the duty value at the period boundary.
module pwm_peripheral #(
    parameter int unsigned DIV = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [15:0] out_q, out_d;
    logic        period_start_q, period_start_d;
    logic        tick;
    logic        wrap;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty_eff;
    logic        pwm_sig;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign tick   = (pre_cnt_q == PRE_LAST);
    assign wrap   = tick && (pwm_cnt_q == 8'hFF);

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_active_q, duty_active_d;

    // Sample the live duty on the wrap edge so the next period uses it whole.
    always_comb begin
        duty_active_d = duty_active_q;
        if (wrap) begin
            duty_active_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_active_q <= 8'h00;
        end else begin
            duty_active_q <= duty_active_d;
        end
    end

    assign duty_eff = duty_active_q;
`else
    assign duty_eff = pwm_duty_cycle;
`endif

    // 0xFF is promoted to a true 100% duty instead of 255/256.
    assign pwm_sig = (duty_eff == 8'hFF) || (pwm_cnt_q < duty_eff);

    always_comb begin
        pre_cnt_d      = tick ? 16'd0 : (pre_cnt_q + 16'd1);
        pwm_cnt_d      = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
        out_d          = en_out & (~en_pwm | {16{pwm_sig}});
        period_start_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= 16'd0;
            pwm_cnt_q      <= 8'd0;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a DIV=1 instance and a DIV=3 instance share stimulus
// and are both checked every cycle against a counting model of the PWM rules.
module tb_pwm_peripheral;
    localparam int DIV_A = 1;
    localparam int DIV_B = 3;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] en_out_v = 16'h0000;
    logic [15:0] en_pwm_v = 16'h0000;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out_a, out_b;
    logic        ps_a_obs, ps_b_obs;

    int total = 0;
    int bad = 0;
    int t_a = 0, t_b = 0;
    logic [7:0] dact_a = 8'h00, dact_b = 8'h00;
    int hi_a = 0;
    int ps_cnt = 0;
    int bad_static = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.DIV(DIV_A)) dut_a (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out_v[7:0]), .en_reg_out_15_8(en_out_v[15:8]),
        .en_reg_pwm_7_0(en_pwm_v[7:0]), .en_reg_pwm_15_8(en_pwm_v[15:8]),
        .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a_obs)
    );

    pwm_peripheral #(.DIV(DIV_B)) dut_b (
        .clk(clk), .rst(rst),
        .en_reg_out_7_0(en_out_v[7:0]), .en_reg_out_15_8(en_out_v[15:8]),
        .en_reg_pwm_7_0(en_pwm_v[7:0]), .en_reg_pwm_15_8(en_pwm_v[15:8]),
        .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b_obs)
    );

    // Output for a given counter step: duty N means N high steps out of 256, 0xFF means all 256.
    function automatic logic [15:0] model_out(int step, logic [7:0] d,
                                              logic [15:0] eo, logic [15:0] ep);
        int high_steps;
        logic pwm;
        logic [15:0] r;
        high_steps = (d == 8'hFF) ? 256 : int'(d);
        pwm = (step < high_steps);
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])      r[i] = 1'b0;
            else if (!ep[i]) r[i] = 1'b1;
            else             r[i] = pwm;
        end
        return r;
    endfunction

    task automatic check16(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict, advance, compare both instances, update the model.
    task automatic step();
        logic [15:0] exp_a, exp_b;
        logic wrap_a, wrap_b;
        logic [7:0] de_a, de_b;
        if (rst) begin
            exp_a = 16'h0; exp_b = 16'h0; wrap_a = 1'b0; wrap_b = 1'b0;
        end else begin
            de_a = SHADOW ? dact_a : duty;
            de_b = SHADOW ? dact_b : duty;
            exp_a = model_out((t_a / DIV_A) % 256, de_a, en_out_v, en_pwm_v);
            exp_b = model_out((t_b / DIV_B) % 256, de_b, en_out_v, en_pwm_v);
            wrap_a = ((t_a + 1) % (256 * DIV_A)) == 0;
            wrap_b = ((t_b + 1) % (256 * DIV_B)) == 0;
        end
        @(posedge clk);
        #1;
        check16("out_a", out_a, exp_a);
        check16("ps_a", {15'b0, ps_a_obs}, {15'b0, wrap_a});
        check16("out_b", out_b, exp_b);
        check16("ps_b", {15'b0, ps_b_obs}, {15'b0, wrap_b});
        if (out_a[0]) hi_a++;
        if (ps_a_obs) ps_cnt++;
        if (out_a !== 16'hA55A) bad_static++;
        if (rst) begin
            t_a = 0; t_b = 0; dact_a = 8'h00; dact_b = 8'h00;
        end else begin
            if (wrap_a) dact_a = duty;
            if (wrap_b) dact_b = duty;
            t_a++; t_b++;
        end
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int found;
        int idx;

        // Reset held 3 cycles with every input at 0xFF.
        rst = 1'b1; en_out_v = 16'hFFFF; en_pwm_v = 16'hFFFF; duty = 8'hFF;
        steps(3);
        check16("reset_out", out_a, 16'h0000);
        rst = 1'b0;
        steps(20);

        // Static outputs.
        en_out_v = 16'hA55A; en_pwm_v = 16'h0000;
        step();
        check16("static_1cyc", out_a, 16'hA55A);
        bad_static = 0;
        steps(256);
        check_int("static_period", bad_static, 0);

        // 50% duty, aligned by a reset; the count is taken over the second period.
        en_out_v = 16'h0001; en_pwm_v = 16'h0001; duty = 8'h80;
        rst = 1'b1; step(); rst = 1'b0;
        ps_cnt = 0;
        steps(256);
        hi_a = 0;
        steps(256);
        check_int("duty80_high", hi_a, 128);
        check_int("duty80_pulses", ps_cnt, 2);

        // Duty extremes, each measured over two periods after a settling period.
        duty = 8'h00;
        steps(256);
        hi_a = 0;
        steps(512);
        check_int("duty00_high", hi_a, 0);
        duty = 8'hFF;
        steps(256);
        hi_a = 0;
        steps(512);
        check_int("dutyFF_high", hi_a, 512);

        // Duty write in the middle of a period.
        duty = 8'h40;
        rst = 1'b1; step(); rst = 1'b0;
        hi_a = 0;
        steps(256);
        check_int("first_period_high", hi_a, SHADOW ? 0 : 64);
        hi_a = 0;
        steps(32);
        duty = 8'hC0;
        steps(224);
        check_int("write_period_high", hi_a, SHADOW ? 64 : 192);
        hi_a = 0;
        steps(256);
        check_int("next_period_high", hi_a, 192);

        // Reset at counter 0x90, then time to the next period pulse.
        duty = 8'h80;
        rst = 1'b1; step(); rst = 1'b0;
        steps(8'h90);
        rst = 1'b1; step();
        check16("midreset_out", out_a, 16'h0000);
        rst = 1'b0;
        found = 0; idx = 0;
        for (int i = 1; i <= 600 && found == 0; i++) begin
            step();
            if (ps_a_obs) begin found = 1; idx = i; end
        end
        check_int("midreset_ps_edge", idx, 256 * DIV_A);

        // Randomized enables, duty writes and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) en_out_v = 16'($urandom);
            if ($urandom_range(0, 15) == 0) en_pwm_v = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: duty = 8'h00;
                    1: duty = 8'hFF;
                    default: duty = 8'($urandom);
                endcase
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
